ppm_eof_detect: RTL

//  Receive-side end-of-frame detector for the PPM link. Counterpart of the transmitter EOF generator.

---
 rtl/ppm_pkg.sv | 22 ++
 rtl/ppm_sync2.sv | 22 ++
 rtl/ppm_eof_detect.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ppm_pkg.sv
// Shared PPM link definitions: EOF detector FSM encoding and the default
// EOF marker shape used by both the transmit generator and receive detector.
package ppm_pkg;

    // EOF detector FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_GAP   = 2'd2,
        ST_ABORT = 2'd3
    } ppm_eof_state_e;

    // Default EOF marker shape: EOF_REPEAT bursts of (HIGH_LEN ones, GAP_LEN zeros)
    localparam int EOF_HIGH_LEN_DEF = 2;
    localparam int EOF_GAP_LEN_DEF  = 4;
    localparam int EOF_REPEAT_DEF   = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ppm_sync2.sv
// Two-flop synchroniser for the asynchronous PPM line, resets to 0.
module ppm_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; q is safe to use in the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ppm_eof_detect.sv
// Receive-side PPM end-of-frame detector. Samples the synchronised line once
// per slot and recognises EOF_REPEAT bursts of EOF_HIGH_LEN high slots each
// closed by EOF_GAP_LEN low slots. Reports a one-cycle pulse and a sticky flag.
// Optional silence timeout: define PPM_EOF_TIMEOUT_EN to add eof_timeout.
module ppm_eof_detect
    import ppm_pkg::*;
#(
    parameter int EOF_HIGH_LEN  = EOF_HIGH_LEN_DEF,
    parameter int EOF_GAP_LEN   = EOF_GAP_LEN_DEF,
    parameter int EOF_REPEAT    = EOF_REPEAT_DEF
`ifdef PPM_EOF_TIMEOUT_EN
   ,parameter int TIMEOUT_SLOTS = 1024
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_en,
    input  logic ppm_in,
    input  logic eof_clr,
    output logic eof_detected,
    output logic eof_flag,
`ifdef PPM_EOF_TIMEOUT_EN
    output logic eof_busy,
    output logic eof_timeout
`else
    output logic eof_busy
`endif
);

    localparam int RW = $clog2(max2(EOF_HIGH_LEN, EOF_GAP_LEN) + 1);
    localparam int PW = $clog2(EOF_REPEAT + 1);
    localparam logic [RW-1:0] HIGH_MAX = RW'(EOF_HIGH_LEN);
    localparam logic [RW-1:0] GAP_LAST = RW'(EOF_GAP_LEN - 1);
    localparam logic [RW-1:0] RUN_ONE  = RW'(1);
    localparam logic [PW-1:0] REP_LAST = PW'(EOF_REPEAT - 1);

    logic           s;
    logic           timeout_set;
    ppm_eof_state_e state;
    logic [RW-1:0]  run_cnt;
    logic [PW-1:0]  rep_cnt;

    ppm_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ppm_in),
        .q     (s)
    );

    // Marker FSM; busy and detect pulse are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            run_cnt      <= '0;
            rep_cnt      <= '0;
            eof_detected <= 1'b0;
            eof_busy     <= 1'b0;
        end else if (!rx_en) begin
            state        <= ST_IDLE;
            run_cnt      <= '0;
            rep_cnt      <= '0;
            eof_detected <= 1'b0;
            eof_busy     <= 1'b0;
        end else begin
            eof_detected <= 1'b0;
            eof_busy     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s) begin
                        state    <= ST_HIGH;
                        run_cnt  <= RUN_ONE;
                        eof_busy <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (s) begin
                        if (run_cnt < HIGH_MAX) begin
                            run_cnt  <= run_cnt + 1'b1;
                            eof_busy <= 1'b1;
                        end else begin
                            // pulse longer than a burst: never a marker
                            state <= ST_ABORT;
                        end
                    end else if (run_cnt == HIGH_MAX) begin
                        state    <= ST_GAP;
                        run_cnt  <= RUN_ONE;
                        eof_busy <= 1'b1;
                    end else begin
                        // ordinary data pulse breaks any partial marker
                        state   <= ST_IDLE;
                        run_cnt <= '0;
                        rep_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (s) begin
                        // gap too short; this high sample may begin a fresh marker
                        state    <= ST_HIGH;
                        run_cnt  <= RUN_ONE;
                        rep_cnt  <= '0;
                        eof_busy <= 1'b1;
                    end else if (run_cnt < GAP_LAST) begin
                        run_cnt  <= run_cnt + 1'b1;
                        eof_busy <= 1'b1;
                    end else begin
                        state   <= ST_IDLE;
                        run_cnt <= '0;
                        if (rep_cnt == REP_LAST) begin
                            eof_detected <= 1'b1;
                            rep_cnt      <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (!s) begin
                        state   <= ST_IDLE;
                        run_cnt <= '0;
                        rep_cnt <= '0;
                    end
                end
            endcase
        end
    end

`ifdef PPM_EOF_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_SLOTS + 1);
    localparam logic [TW-1:0] SIL_MAX = TW'(TIMEOUT_SLOTS);

    logic [TW-1:0] sil_cnt;

    // Silence counter: counts low slots, pulses once on reaching the limit, then holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sil_cnt     <= '0;
            eof_timeout <= 1'b0;
        end else begin
            eof_timeout <= 1'b0;
            if (!rx_en || s) begin
                sil_cnt <= '0;
            end else if (sil_cnt < SIL_MAX) begin
                sil_cnt <= sil_cnt + 1'b1;
                if (sil_cnt == SIL_MAX - 1'b1)
                    eof_timeout <= 1'b1;
            end
        end
    end

    assign timeout_set = eof_timeout;
`else
    assign timeout_set = 1'b0;
`endif

    // Sticky flag; a new event in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            eof_flag <= 1'b0;
        else if (eof_detected || timeout_set)
            eof_flag <= 1'b1;
        else if (eof_clr)
            eof_flag <= 1'b0;
    end

endmodule
